// File: rtl/vram_arbiter.sv
// Screen RAM owner: single-port 8-bit RAM time-shared between video fetch
// and the Z80 bus, with video holding phases 10..15 of every character cell.
module vram_arbiter #(
  parameter int    ADDR_W      = 13,
  parameter int    CPU_LAST_PH = 8,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic [3:0]        vid_phase,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [15:0]       stall_cnt
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAST  = 4'(CPU_LAST_PH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_mem [DEPTH];
  logic [7:0]        r_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic              r_ack;
  logic [7:0]        r_rdata;
  logic [15:0]       r_stall;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic              w_win;
  logic              w_wait;

  assign w_win      = (vid_phase <= LAST);
  assign w_ram_addr = (r_state == S_ACCESS) ? r_addr : vid_addr;
  assign w_ram_we   = (r_state == S_ACCESS) & r_we & ~reset;
  assign w_wait     = cpu_req & (r_state == S_IDLE) & ~w_win;

  // Contents are deliberately not reset; only the output register is.
  always_ff @(posedge clk_pix) begin
    if (w_ram_we) r_mem[w_ram_addr] <= r_wdata;
  end

  always_ff @(posedge clk_pix) begin
    if (reset) r_q <= '0;
    else       r_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_stall <= '0;
    end else begin
      if (w_wait && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (cpu_req && w_win) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_ack   <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_ack <= 1'b0;
          if (!r_we) r_rdata <= r_q;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          r_ack <= 1'b0;
          // A request held past its ack must drop before a new one counts.
          if (!cpu_req) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vid_data  = r_q;
  assign cpu_rdata = r_rdata;
  assign cpu_ack   = r_ack;
  assign cpu_wait  = w_wait;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed + randomized bench for vram_arbiter with scoreboard queues
// for video fetches and CPU reads.
module tb_vram_arbiter;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic [3:0]  vid_phase;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [15:0] stall_cnt;

  vram_arbiter #(
    .ADDR_W(13),
    .CPU_LAST_PH(8),
    .INIT_FILE("")
  ) dut (
    .clk_pix(clk_pix),
    .reset(reset),
    .vid_phase(vid_phase),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait),
    .stall_cnt(stall_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  logic [7:0]  model [8192];
  logic [7:0]  vq [$];
  logic [7:0]  cq [$];
  logic [3:0]  phase;
  logic        force_en;
  logic [12:0] force_addr;
  int          cells;
  int          vec;
  int          errs;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock; video presents at 11/13 and is checked at 12/14.
  task automatic tick();
    @(posedge clk_pix);
    #1;
    phase = phase + 4'd1;
    vid_phase = phase;
    if (phase == 4'd0) cells++;
    if (phase == 4'd11 || phase == 4'd13) begin
      vid_addr = force_en ? force_addr : 13'($urandom);
      vq.push_back(model[vid_addr]);
    end
    #1;
    if ((phase == 4'd12 || phase == 4'd14) && vq.size() > 0)
      chk("vid_data", {24'd0, vid_data}, {24'd0, vq.pop_front()});
  endtask

  task automatic wait_phase(input logic [3:0] p);
    for (int i = 0; i < 17 && phase != p; i++) tick();
  endtask

  task automatic cpu_op(input logic we, input logic [12:0] a,
                        input logic [7:0] d, output int ack_ph,
                        output int waits);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (!we) cq.push_back(model[a]);
    ack_ph = -1;
    waits  = 0;
    #1;
    waits += int'(cpu_wait);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_ack) begin
        ack_ph = int'(phase);
        break;
      end
      waits += int'(cpu_wait);
    end
    cpu_req = 1'b0;
    chk("ack_seen", 32'(ack_ph >= 0), 32'd1);
    chk("ack_window", 32'(ack_ph >= 1 && ack_ph <= 10), 32'd1);
    if (we && ack_ph >= 0) model[a] = d;
    tick();
    if (!we) chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cq.pop_front()});
    tick();
  endtask

  initial begin
    int ap;
    int w;
    int extra;
    logic [7:0] exp6;
    vec = 0;
    errs = 0;
    cells = 0;
    phase = 4'd0;
    vid_phase = 4'd0;
    vid_addr = '0;
    force_en = 1'b0;
    force_addr = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    reset = 1'b1;

    for (int i = 0; i < 8192; i++) begin
      model[i] = 8'($urandom);
      dut.r_mem[i] = model[i];
    end
    model[0] = 8'hA5;
    dut.r_mem[0] = 8'hA5;
    model[16] = 8'h33;
    dut.r_mem[16] = 8'h33;

    tick();
    tick();
    chk("rst_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_vid_data", {24'd0, vid_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Read in the open window.
    wait_phase(4'd0);
    cpu_op(1'b0, 13'h0000, 8'h00, ap, w);
    chk("t1_ack_phase", 32'(ap), 32'd2);
    chk("t1_waits", 32'(w), 32'd0);
    chk("t1_stall", {16'd0, stall_cnt}, 32'd0);

    // Request just after the window closes.
    wait_phase(4'd9);
    cpu_op(1'b0, 13'h0001, 8'h00, ap, w);
    chk("t2_ack_phase", 32'(ap), 32'd2);
    chk("t2_waits", 32'(w), 32'd7);
    chk("t2_stall", {16'd0, stall_cnt}, 32'd7);

    // CPU write then video fetch of the same byte.
    wait_phase(4'd3);
    cpu_op(1'b1, 13'h1800, 8'h5A, ap, w);
    chk("t3_ack_phase", 32'(ap), 32'd5);
    force_addr = 13'h1800;
    force_en = 1'b1;
    wait_phase(4'd12);
    force_en = 1'b0;
    chk("t3_vid", {24'd0, vid_data}, 32'h5A);

    // Random CPU traffic against a scanning video.
    while (cells < 1000)
      cpu_op(1'($urandom), 13'($urandom), 8'($urandom), ap, w);

    // Reset landing on the ACCESS cycle of a write.
    exp6 = model[16];
    wait_phase(4'd2);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 13'h0010;
    cpu_wdata = 8'hFF;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_ack", {31'd0, cpu_ack}, 32'd0);
    chk("t5_stall", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    cpu_req = 1'b0;
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      extra += int'(cpu_ack);
    end
    chk("t5_no_ack", 32'(extra), 32'd0);
    wait_phase(4'd0);
    cpu_op(1'b0, 13'h0010, 8'h00, ap, w);
    chk("t5_idle_latency", 32'(ap), 32'd2);
    chk("t5_mem_kept", {24'd0, cpu_rdata}, {24'd0, exp6});

    // Request held long after its ack.
    wait_phase(4'd0);
    exp6 = model[13'h0100];
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 13'h0100;
    ap = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cpu_ack) begin
        ap = int'(phase);
        break;
      end
    end
    chk("t6_ack_phase", 32'(ap), 32'd2);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      extra += int'(cpu_ack);
    end
    chk("t6_rdata", {24'd0, cpu_rdata}, {24'd0, exp6});
    chk("t6_single_access", 32'(extra), 32'd0);
    cpu_req = 1'b0;
    tick();
    cpu_op(1'b0, 13'h0100, 8'h00, ap, w);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
